rv32i_itcm_arbiter: RTL and testbench

Arbitrates a single-port instruction TCM between the instruction-fetch port and the load/store port, which also serves as the program loader. Each cycle it grants at most one request onto the RAM port. It tracks which requester owns the in-flight access and returns that access's read data or write acknowledgement one cycle later. The block sits between the core's fetch/LSU interfaces and the ITCM wrapper, which has one-cycle registered-read RAM and per-byte write mask.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_itcm_arbiter_if.sv | 56 +++++
 rtl/rv32i_prio_starve.sv | 54 +++++
 rtl/rv32i_itcm_arbiter.sv | 93 +++++++++
 tb/tb_rv32i_itcm_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I tightly-coupled memory arbiters.
//   rsp_owner_e     : owner of the in-flight RAM access (NONE/IF/LD/ST)
//   ITCM_ADDR_WIDTH : ITCM byte address width
//   ITCM_RAM_SIZE   : ITCM size in bytes
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int unsigned ITCM_ADDR_WIDTH = 16;
    localparam int unsigned ITCM_RAM_SIZE   = 1 << ITCM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } rsp_owner_e;

endpackage

// File: rtl/rv32i_itcm_arbiter_if.sv
// -----------------------------------------------------------------------------
// rv32i_itcm_arbiter_if
// Bundles the fetch port, the load/store port and the ITCM RAM port of the
// ITCM arbiter.
//   slave  : the arbiter side (takes requests and RAM read data, drives
//            readies, responses and the RAM access)
//   master : the core/RAM side (drives requests and RAM read data)
// -----------------------------------------------------------------------------
interface rv32i_itcm_arbiter_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MASK_WIDTH = 4
);
    // Fetch port
    logic                    if_req_valid;
    logic                    if_req_ready;
    logic [ADDR_WIDTH-1:0]   if_req_addr;
    logic                    if_rsp_valid;
    logic [WORD_WIDTH-1:0]   if_rsp_rdata;

    // Load/store port
    logic                    ls_req_valid;
    logic                    ls_req_ready;
    logic [ADDR_WIDTH-1:0]   ls_req_addr;
    logic [MASK_WIDTH-1:0]   ls_req_wen;
    logic [WORD_WIDTH-1:0]   ls_req_wdata;
    logic                    ls_rsp_valid;
    logic [WORD_WIDTH-1:0]   ls_rsp_rdata;

    // RAM port
    logic                    ram_cs;
    logic                    ram_we;
    logic [MASK_WIDTH-1:0]   ram_wem;
    logic [ADDR_WIDTH-3:0]   ram_addr;
    logic [WORD_WIDTH-1:0]   ram_wdata;
    logic [WORD_WIDTH-1:0]   ram_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output ram_cs, ram_we, ram_wem, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  ram_cs, ram_we, ram_wem, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/rv32i_prio_starve.sv
// -----------------------------------------------------------------------------
// rv32i_prio_starve
// Two-input fixed-priority selector with a starvation counter. The high
// priority input wins contention unless the low priority input has been
// denied STARVE_MAX consecutive cycles, in which case the low input wins.
//   clk, rst_n  : clock, asynchronous active-low reset
//   hi_valid_i  : high priority request (load/store on the ITCM)
//   lo_valid_i  : low priority request (fetch on the ITCM)
//   hi_grant_o  : high priority request granted this cycle
//   lo_grant_o  : low priority request granted this cycle
// -----------------------------------------------------------------------------
module rv32i_prio_starve #(
    parameter int unsigned STARVE_MAX = 4   // 1..15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hi_valid_i,
    input  logic lo_valid_i,
    output logic hi_grant_o,
    output logic lo_grant_o
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       starved;

    assign starved = (starve_cnt_q == CNT_MAX);

    // Grants are exclusive by construction: hi only when lo is not granted.
    always_comb begin
        lo_grant_o = lo_valid_i & (~hi_valid_i | starved);
        hi_grant_o = hi_valid_i & ~lo_grant_o;
    end

    // Counts consecutive denials of a pending low request; any cycle where
    // the low side is granted or idle restarts the count.
    always_comb begin
        starve_cnt_d = '0;
        if (lo_valid_i && !lo_grant_o) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/rv32i_itcm_arbiter.sv
// -----------------------------------------------------------------------------
// rv32i_itcm_arbiter
// Shares a single-port ITCM (one-cycle registered read, per-byte write mask)
// between instruction fetch and the load/store unit (which also acts as the
// program loader). At most one request is granted per cycle; the response
// for a grant in cycle T is presented in T+1 to the owning requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_if     : fetch port, load/store port and RAM port (slave modport)
// -----------------------------------------------------------------------------
module rv32i_itcm_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = ITCM_ADDR_WIDTH,
    parameter int unsigned MASK_WIDTH = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32i_itcm_arbiter_if.slave   bus_if
);

    logic       if_valid;
    logic       ls_valid;
    logic       if_gnt;
    logic       ls_gnt;
    rsp_owner_e rsp_owner_q;
    rsp_owner_e rsp_owner_d;
    logic       unused_addr_lsb;

    // Requests are masked while reset is held so every output reads 0.
    assign if_valid = bus_if.if_req_valid & rst_n;
    assign ls_valid = bus_if.ls_req_valid & rst_n;

    rv32i_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .hi_valid_i (ls_valid),
        .lo_valid_i (if_valid),
        .hi_grant_o (ls_gnt),
        .lo_grant_o (if_gnt)
    );

    assign bus_if.if_req_ready = if_gnt;
    assign bus_if.ls_req_ready = ls_gnt;

    // RAM drive; byte offset bits are dropped, idle cycles drive zero.
    always_comb begin
        bus_if.ram_cs    = if_gnt | ls_gnt;
        bus_if.ram_addr  = '0;
        bus_if.ram_wem   = '0;
        bus_if.ram_wdata = '0;
        if (ls_gnt) begin
            bus_if.ram_addr  = bus_if.ls_req_addr[ADDR_WIDTH-1:2];
            bus_if.ram_wem   = bus_if.ls_req_wen;
            bus_if.ram_wdata = bus_if.ls_req_wdata;
        end else if (if_gnt) begin
            bus_if.ram_addr  = bus_if.if_req_addr[ADDR_WIDTH-1:2];
        end
    end

    assign bus_if.ram_we   = |bus_if.ram_wem;
    assign unused_addr_lsb = ^{bus_if.if_req_addr[1:0], bus_if.ls_req_addr[1:0]};

    always_comb begin
        rsp_owner_d = OWN_NONE;
        if (if_gnt) begin
            rsp_owner_d = OWN_IF;
        end else if (ls_gnt) begin
            rsp_owner_d = (|bus_if.ls_req_wen) ? OWN_ST : OWN_LD;
        end
    end

    // Reset clears the owner, which drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner_q <= OWN_NONE;
        end else begin
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Response steering from the registered owner; RAM data is valid now.
    always_comb begin
        bus_if.if_rsp_valid = (rsp_owner_q == OWN_IF);
        bus_if.if_rsp_rdata = (rsp_owner_q == OWN_IF) ? bus_if.ram_rdata : '0;
        bus_if.ls_rsp_valid = (rsp_owner_q == OWN_LD) || (rsp_owner_q == OWN_ST);
        bus_if.ls_rsp_rdata = (rsp_owner_q == OWN_LD) ? bus_if.ram_rdata : '0;
    end

endmodule

// File: tb/tb_rv32i_itcm_arbiter.sv
module tb_rv32i_itcm_arbiter;

    localparam int unsigned SMAX = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    rv32i_itcm_arbiter_if #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .MASK_WIDTH(4)) bus ();

    rv32i_itcm_arbiter #(
        .WORD_WIDTH (32),
        .ADDR_WIDTH (16),
        .MASK_WIDTH (4),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        case (i)
            0:       return 32'h0000_0011;
            1:       return 32'h0000_0022;
            2:       return 32'h0000_0033;
            4:       return 32'h1234_5678;
            default: return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
        endcase
    endfunction

    // ---------------- environment RAM: registered read, byte write mask
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.ram_cs) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wem[b]) mem[bus.ram_addr[7:0]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
                if (!bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr[7:0]];
            end
        end
    end

    // ---------------- reference model state and scoreboard
    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [256];
    int          denials;
    logic        exp_if_rdy, exp_ls_rdy, exp_cs;
    logic [13:0] exp_addr;
    logic [3:0]  exp_wem;
    logic [31:0] exp_wdata;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_exp();
        exp_if_rdy = 0; exp_ls_rdy = 0; exp_cs = 0;
        exp_addr = '0; exp_wem = '0; exp_wdata = '0;
    endtask

    // One cycle of stimulus plus the model's prediction for it.
    task automatic step(bit ifv, logic [15:0] ifa, bit lsv, logic [15:0] lsa,
                        logic [3:0] wen, logic [31:0] wd);
        bit gi, gl;
        int w;
        @(posedge clk);
        #1;
        bus.if_req_valid = ifv;
        bus.if_req_addr  = ifa;
        bus.ls_req_valid = lsv;
        bus.ls_req_addr  = lsa;
        bus.ls_req_wen   = wen;
        bus.ls_req_wdata = wd;
        if (ifv && lsv) begin
            gi = (denials == SMAX);
            gl = !gi;
        end else begin
            gi = ifv;
            gl = lsv;
        end
        denials = (ifv && !gi) ? ((denials < 15) ? denials + 1 : 15) : 0;
        clear_exp();
        exp_if_rdy = gi;
        exp_ls_rdy = gl;
        exp_cs     = gi | gl;
        if (gl) begin
            w         = int'(lsa) / 4;
            exp_addr  = 14'(w);
            exp_wem   = wen;
            exp_wdata = wd;
            if (wen == 0) begin
                sb_q.push_back('{is_if: 0, data: ref_mem[w], due: cyc + 1});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
                sb_q.push_back('{is_if: 0, data: 32'h0, due: cyc + 1});
            end
        end else if (gi) begin
            w        = int'(ifa) / 4;
            exp_addr = 14'(w);
            sb_q.push_back('{is_if: 1, data: ref_mem[w], due: cyc + 1});
        end
    endtask

    task automatic apply_reset(int n);
        @(posedge clk);
        #1;
        rst_n = 0;
        bus.if_req_valid = 0;
        bus.ls_req_valid = 0;
        sb_q.delete();
        denials = 0;
        clear_exp();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // ---------------- monitor: checks outputs on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_ctrl",
                    64'({bus.if_req_ready, bus.ls_req_ready, bus.if_rsp_valid, bus.ls_rsp_valid,
                         bus.ram_cs, bus.ram_we, bus.ram_wem, bus.ram_addr}), 64'h0);
                chk("reset_rdata", {bus.if_rsp_rdata, bus.ls_rsp_rdata}, 64'h0);
                chk("reset_wdata", 64'(bus.ram_wdata), 64'h0);
            end else begin
                bit   have;
                exp_t e;
                chk("if_req_ready", 64'(bus.if_req_ready), 64'(exp_if_rdy));
                chk("ls_req_ready", 64'(bus.ls_req_ready), 64'(exp_ls_rdy));
                chk("ram_cs", 64'(bus.ram_cs), 64'(exp_cs));
                chk("ram_addr", 64'(bus.ram_addr), 64'(exp_addr));
                chk("ram_wem", 64'(bus.ram_wem), 64'(exp_wem));
                chk("ram_we", 64'(bus.ram_we), 64'(|exp_wem));
                chk("ram_wdata", 64'(bus.ram_wdata), 64'(exp_wdata));
                have = (sb_q.size() > 0) && (sb_q[0].due == cyc);
                if (have) e = sb_q.pop_front();
                chk("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(have && e.is_if));
                chk("if_rsp_rdata", 64'(bus.if_rsp_rdata), 64'((have && e.is_if) ? e.data : 32'h0));
                chk("ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'(have && !e.is_if));
                chk("ls_rsp_rdata", 64'(bus.ls_rsp_rdata), 64'((have && !e.is_if) ? e.data : 32'h0));
            end
        end
    end

    // ---------------- stimulus
    initial begin
        n_cmp = 0;
        n_bad = 0;
        denials = 0;
        rst_n = 0;
        bus.if_req_valid = 0;
        bus.if_req_addr  = '0;
        bus.ls_req_valid = 0;
        bus.ls_req_addr  = '0;
        bus.ls_req_wen   = '0;
        bus.ls_req_wdata = '0;
        clear_exp();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        // fetch-only, back-to-back
        step(1, 16'h0000, 0, 0, 0, 0);
        step(1, 16'h0004, 0, 0, 0, 0);
        step(1, 16'h0008, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // partial store then load, then unaligned load of the same word
        step(0, 0, 1, 16'h0010, 4'b0011, 32'hAABB_CCDD);
        step(0, 0, 1, 16'h0010, 4'b0000, 32'h0);
        step(0, 0, 1, 16'h0013, 4'b0000, 32'h0);
        step(0, 0, 0, 0, 0, 0);

        // full contention: LS x4 then IF, repeating
        for (int i = 0; i < 15; i++) step(1, 16'(4 * i), 1, 16'(16'h0100 + 4 * i), 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // LS on alternate cycles, IF always pending
        for (int i = 0; i < 12; i++) step(1, 16'(16'h0040 + 4 * i), (i % 2) == 0, 16'h0080, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // reset in the response cycle of a fetch grant
        step(1, 16'h0004, 0, 0, 0, 0);
        apply_reset(2);
        step(1, 16'h0008, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          ifv, lsv;
            logic [3:0]  wen;
            ifv = ($urandom % 4) != 0;
            lsv = ($urandom % 3) != 0;
            wen = ($urandom % 2) ? 4'($urandom) : 4'h0;
            step(ifv, 16'($urandom_range(0, 1023)), lsv, 16'($urandom_range(0, 1023)), wen, $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
